// File: rtl/decimal_key_debouncer_if.sv
// Key front-end bundle: raw button lines in, debounced one-hot key and strobes out.
interface decimal_key_debouncer_if;
  logic [9:0] key_raw;
  logic [9:0] key_onehot;
  logic       key_valid;
  logic       multi_err;
  logic       busy;

  modport master (
    output key_raw,
    input  key_onehot, key_valid, multi_err, busy
  );

  modport slave (
    input  key_raw,
    output key_onehot, key_valid, multi_err, busy
  );
endinterface

// File: rtl/decimal_key_debouncer.sv
// Synchronises and debounces ten digit keys, forwarding only single-key presses.
// Define KEY_REPEAT_EN to add auto-repeat strobes while a key stays held.
module decimal_key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  decimal_key_debouncer_if.slave  kif
);

  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t        state_reg, state_next;
  logic [9:0]    sync1_reg;
  logic [9:0]    s_reg;
  logic [9:0]    cand_reg, cand_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [9:0]    onehot_reg, onehot_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;
  logic          busy_reg;
  logic          cand_is_onehot;
`ifdef KEY_REPEAT_EN
  logic          rpt_first_reg, rpt_first_next;
`endif

  // Clearing the lowest set bit leaves zero only for a single-bit pattern.
  assign cand_is_onehot = (cand_reg != 10'd0) && ((cand_reg & (cand_reg - 10'd1)) == 10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= '0;
      s_reg      <= '0;
      state_reg  <= IDLE;
      cand_reg   <= '0;
      cnt_reg    <= '0;
      onehot_reg <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_first_reg <= 1'b0;
`endif
    end else begin
      sync1_reg  <= kif.key_raw;
      s_reg      <= sync1_reg;
      state_reg  <= state_next;
      cand_reg   <= cand_next;
      cnt_reg    <= cnt_next;
      onehot_reg <= onehot_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
      busy_reg   <= (state_reg != IDLE);
`ifdef KEY_REPEAT_EN
      rpt_first_reg <= rpt_first_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    cand_next   = cand_reg;
    cnt_next    = cnt_reg;
    onehot_next = onehot_reg;
    valid_next  = 1'b0;
    err_next    = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_first_next = rpt_first_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (s_reg != 10'd0) begin
          cand_next  = s_reg;
          cnt_next   = '0;
          state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s_reg == 10'd0) begin
          state_next = IDLE;
        end else if (s_reg != cand_reg) begin
          cand_next = s_reg;
          cnt_next  = '0;
        end else if (cnt_reg == DB_LAST) begin
          // cnt restarts here so the repeat timer runs from the accept edge.
          cnt_next = '0;
          if (cand_is_onehot) begin
            onehot_next = cand_reg;
            valid_next  = 1'b1;
            state_next  = PRESSED;
`ifdef KEY_REPEAT_EN
            rpt_first_next = 1'b1;
`endif
          end else begin
            err_next   = 1'b1;
            state_next = RELEASE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        if (s_reg != onehot_reg) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end
`ifdef KEY_REPEAT_EN
        else if (cnt_reg == (rpt_first_reg ? RD_LAST : RR_LAST)) begin
          valid_next     = 1'b1;
          cnt_next       = '0;
          rpt_first_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      RELEASE: begin
        // Every key must be up and stable before anything new is accepted.
        if (s_reg != 10'd0) begin
          cnt_next = '0;
        end else if (cnt_reg == DB_LAST) begin
          cnt_next    = '0;
          onehot_next = '0;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign kif.key_onehot = onehot_reg;
  assign kif.key_valid  = valid_reg;
  assign kif.multi_err  = err_reg;
  assign kif.busy       = busy_reg;

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Scoreboard bench for decimal_key_debouncer: expected output events are queued
// with their edge numbers and an independent negedge monitor matches them.
module tb_decimal_key_debouncer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  decimal_key_debouncer_if kif();

  decimal_key_debouncer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int EV_VALID = 0;
  localparam int EV_ERR   = 1;
  localparam int EV_REL   = 2;
  localparam int EV_IDLE  = 3;

  typedef struct {
    int         kind;
    int         at;
    logic [9:0] oh;
  } ev_t;

  ev_t exp_q[$];

  task automatic expect_ev(input int kind, input int at, input logic [9:0] oh);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.oh   = oh;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic observe(input int kind, input logic [9:0] oh);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual kind=%0d cycle=%0d oh=%b required none", kind, cyc, oh);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc || e.oh != oh) begin
        errors++;
        $display("FAIL event actual kind=%0d cycle=%0d oh=%b required kind=%0d cycle=%0d oh=%b",
                 kind, cyc, oh, e.kind, e.at, e.oh);
      end else begin
        $display("event kind=%0d cycle=%0d oh=%b ok", kind, cyc, oh);
      end
    end
  endtask

  // Monitor: reports strobes, key_onehot falling to 0 and busy falling.
  logic [9:0] prev_oh = '0;
  logic       prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_oh   = '0;
      prev_busy = 1'b0;
    end else begin
      if (kif.key_valid && kif.multi_err) begin
        checks++;
        errors++;
        $display("FAIL strobe_overlap actual valid=1 err=1 required not both at cycle %0d", cyc);
      end
      if (kif.key_valid) observe(EV_VALID, kif.key_onehot);
      if (kif.multi_err) observe(EV_ERR, kif.key_onehot);
      if (prev_oh != 10'd0 && kif.key_onehot == 10'd0) observe(EV_REL, 10'd0);
      if (prev_busy && !kif.busy) observe(EV_IDLE, 10'd0);
      prev_oh   = kif.key_onehot;
      prev_busy = kif.busy;
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start(input logic [9:0] v, output int t);
    @(negedge clk);
    kif.key_raw = v;
    t = cyc;
  endtask

  task automatic set_at(input int c, input logic [9:0] v);
    wait_to(c);
    kif.key_raw = v;
  endtask

  initial begin
    int t0;
    int t1;
    kif.key_raw = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_onehot", int'(kif.key_onehot), 0);
    chk("reset_valid", int'(kif.key_valid), 0);
    chk("reset_err", int'(kif.multi_err), 0);
    chk("reset_busy", int'(kif.busy), 0);

    // Clean press of key 3
    start(10'b0000001000, t0);
    expect_ev(EV_VALID, t0 + 19, 10'b0000001000);
    expect_ev(EV_REL,   t0 + 59, 10'd0);
    expect_ev(EV_IDLE,  t0 + 60, 10'd0);
    set_at(t0 + 40, 10'd0);
    wait_to(t0 + 75);

    // Key 5 bouncing every 3 cycles, then held
    start(10'b0000100000, t0);
    expect_ev(EV_IDLE,  t0 + 7,  10'd0);
    expect_ev(EV_IDLE,  t0 + 13, 10'd0);
    expect_ev(EV_VALID, t0 + 31, 10'b0000100000);
    expect_ev(EV_REL,   t0 + 71, 10'd0);
    expect_ev(EV_IDLE,  t0 + 72, 10'd0);
    set_at(t0 + 3,  10'd0);
    set_at(t0 + 6,  10'b0000100000);
    set_at(t0 + 9,  10'd0);
    set_at(t0 + 12, 10'b0000100000);
    set_at(t0 + 52, 10'd0);
    wait_to(t0 + 85);

    // Two keys at once: rejected
    start(10'b0000001010, t0);
    expect_ev(EV_ERR,  t0 + 19, 10'd0);
    expect_ev(EV_IDLE, t0 + 59, 10'd0);
    set_at(t0 + 30, 10'b0000001010);
    chk("multi_busy_held", int'(kif.busy), 1);
    set_at(t0 + 40, 10'd0);
    wait_to(t0 + 75);

    // Short glitch on key 9
    start(10'b1000000000, t0);
    expect_ev(EV_IDLE, t0 + 14, 10'd0);
    set_at(t0 + 10, 10'd0);
    wait_to(t0 + 30);

    // Reset in the middle of a key-2 hold, key still held afterwards
    start(10'b0000000100, t0);
    wait_to(t0 + 10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_onehot", int'(kif.key_onehot), 0);
    chk("midrst_valid", int'(kif.key_valid), 0);
    chk("midrst_err", int'(kif.multi_err), 0);
    chk("midrst_busy", int'(kif.busy), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    t1 = cyc;
    expect_ev(EV_VALID, t1 + 19, 10'b0000000100);
    expect_ev(EV_REL,   t1 + 59, 10'd0);
    expect_ev(EV_IDLE,  t1 + 60, 10'd0);
    set_at(t1 + 40, 10'd0);
    wait_to(t1 + 75);

    // Key 0 held for 200 cycles
    start(10'b0000000001, t0);
    expect_ev(EV_VALID, t0 + 19, 10'b0000000001);
`ifdef KEY_REPEAT_EN
    for (int k = 83; k <= 195; k += 16) expect_ev(EV_VALID, t0 + k, 10'b0000000001);
`endif
    expect_ev(EV_REL,  t0 + 219, 10'd0);
    expect_ev(EV_IDLE, t0 + 220, 10'd0);
    set_at(t0 + 200, 10'd0);
    wait_to(t0 + 240);

    chk("pending_events", exp_q.size(), 0);
    chk("final_busy", int'(kif.busy), 0);
    chk("final_onehot", int'(kif.key_onehot), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
